// File: rtl/exibidor_sequencia_pkg.sv
// Shared state codes and helpers for the LED sequence player.
// State codes double as the 7-seg debug value.
package exibidor_sequencia_pkg;

  typedef enum logic [3:0] {
    EXB_IDLE    = 4'h0,
    EXB_LE      = 4'h1,
    EXB_ACESO   = 4'h3,
    EXB_APAGADO = 4'h5,
    EXB_PROXIMO = 4'h6,
    EXB_FIM     = 4'hF
  } estado_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear.
// Used as the dwell timer of the sequence player.
module contador_m #(
  parameter int M = 4,
  parameter int W = $clog2(M + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_zera,
  input  logic         i_conta,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // count 0..M-1 while enabled; clear wins over count
  always_ff @(posedge i_clk) begin
    if (i_rst || i_zera) begin
      r_q <= '0;
    end else if (i_conta) begin
      r_q <= (r_q == W'(M - 1)) ? '0 : r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/exibidor_sequencia.sv
// Plays RAM colours 0..limite on the LEDs, lit T_ACESO
// then blank T_APAGADO cycles each, then pulses fim.
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int T_ACESO   = 25_000_000,
  parameter int T_APAGADO = 12_500_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              fim,
  output logic [3:0]        db_estado
);

  localparam int MAXT = max_int(T_ACESO, T_APAGADO);
  localparam int TW   = $clog2(MAXT + 1);

  estado_t           r_estado;
  estado_t           w_prox;
  logic [ADDR_W-1:0] r_lim;
  logic [ADDR_W-1:0] r_end;
  logic [DATA_W-1:0] r_leds;
  logic [TW-1:0]     w_q;
  logic              w_zera;
  logic              w_conta;
  logic              w_fim_aceso;
  logic              w_fim_apag;

  assign w_fim_aceso = (w_q == TW'(T_ACESO - 1));
  assign w_fim_apag  = (w_q == TW'(T_APAGADO - 1));

  // timer restarts on every state change
  assign w_zera  = (w_prox != r_estado);
  assign w_conta = (r_estado == EXB_ACESO) ||
                   (r_estado == EXB_APAGADO);

  contador_m #(
    .M (MAXT),
    .W (TW)
  ) u_timer (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_zera  (w_zera),
    .i_conta (w_conta),
    .o_q     (w_q)
  );

  // next-state: abort overrides everything outside IDLE
  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      EXB_IDLE:    if (iniciar && !abortar) w_prox = EXB_LE;
      EXB_LE:      w_prox = EXB_ACESO;
      EXB_ACESO:   if (w_fim_aceso) w_prox = EXB_APAGADO;
      EXB_APAGADO: begin
        if (w_fim_apag) begin
          w_prox = (r_end == r_lim) ? EXB_FIM : EXB_PROXIMO;
        end
      end
      EXB_PROXIMO: w_prox = EXB_LE;
      EXB_FIM:     w_prox = EXB_IDLE;
      default:     w_prox = EXB_IDLE;
    endcase
    if (abortar && r_estado != EXB_IDLE) begin
      w_prox = EXB_IDLE;
    end
  end

  // state, latched limit, address and LED registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= EXB_IDLE;
      r_lim    <= '0;
      r_end    <= '0;
      r_leds   <= '0;
    end else begin
      r_estado <= w_prox;
      if (r_estado == EXB_IDLE && w_prox == EXB_LE) begin
        r_lim <= limite;
        r_end <= '0;
      end else if (w_prox == EXB_IDLE) begin
        r_end <= '0;
      end else if (r_estado == EXB_PROXIMO) begin
        r_end <= r_end + 1'b1;
      end
      if (w_prox != EXB_ACESO) begin
        r_leds <= '0;
      end else if (r_estado == EXB_LE) begin
        r_leds <= dado_memoria;
      end
    end
  end

  assign endereco  = r_end;
  assign leds      = r_leds;
  assign ocupado   = (r_estado != EXB_IDLE);
  assign fim       = (r_estado == EXB_FIM);
  assign db_estado = r_estado;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Bench for exibidor_sequencia: directed and random playbacks
// compared with a timing/sequence model built from the rules.
module tb_exibidor_sequencia;

  localparam int TA = 4;
  localparam int TP = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       abortar;
  logic [3:0] limite;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       fim;
  logic [3:0] db_estado;

  logic [3:0] mem [16];

  int checks   = 0;
  int failures = 0;

  int         cyc     = 0;
  int         busy    = 0;
  int         fims    = 0;
  int         run     = 0;
  int         max_end = 0;
  logic [3:0] prev    = '0;
  bit         mon_clr = 1'b0;
  logic [3:0] lit_v[$];
  int         lit_s[$];
  int         lit_l[$];

  exibidor_sequencia #(
    .ADDR_W    (4),
    .DATA_W    (4),
    .T_ACESO   (TA),
    .T_APAGADO (TP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .abortar      (abortar),
    .limite       (limite),
    .dado_memoria (dado_memoria),
    .endereco     (endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .fim          (fim),
    .db_estado    (db_estado)
  );

  assign dado_memoria = mem[endereco];

  always #5 clock = ~clock;

  // observer: lit intervals, busy cycles, fim pulses, max address
  always @(negedge clock) begin
    cyc++;
    if (mon_clr) begin
      busy = 0; fims = 0; run = 0; max_end = 0; prev = '0;
      lit_v.delete(); lit_s.delete(); lit_l.delete();
    end else begin
      if (ocupado) busy++;
      if (fim) fims++;
      if (ocupado && int'(endereco) > max_end) max_end = int'(endereco);
      if (leds != 0 && prev == 0) begin
        lit_v.push_back(leds);
        lit_s.push_back(cyc);
      end
      if (leds != 0) run++;
      else if (run != 0) begin
        lit_l.push_back(run);
        run = 0;
      end
      prev = leds;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    @(posedge clock); #1 mon_clr = 1'b1;
    @(posedge clock); #1 mon_clr = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (!ocupado) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic play(input int lim, input bit disturb);
    int n;
    int nv;
    bit ok;
    n = lim + 1;
    clr();
    limite  = 4'(lim);
    iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    if (disturb) begin
      repeat (10) @(posedge clock);
      #1 limite = 4'd0;
      iniciar = 1'b1;
      @(posedge clock); #1 iniciar = 1'b0;
    end
    wait_idle(ok);
    chk($sformatf("done_L%0d", lim), ok, 1);
    @(posedge clock); #1;
    chk($sformatf("busy_L%0d", lim), busy,
        n * (TA + TP + 1) + (n - 1) + 1);
    chk($sformatf("fim_L%0d", lim), fims, 1);
    chk($sformatf("nlit_L%0d", lim), lit_v.size(), n);
    chk($sformatf("maxend_L%0d", lim), max_end, lim);
    chk($sformatf("ocup_L%0d", lim), ocupado, 0);
    chk($sformatf("leds_L%0d", lim), leds, 0);
    nv = (lit_v.size() < n) ? lit_v.size() : n;
    for (int i = 0; i < nv; i++) begin
      chk($sformatf("val_L%0d_%0d", lim, i), lit_v[i], mem[i]);
      if (i < lit_l.size())
        chk($sformatf("len_L%0d_%0d", lim, i), lit_l[i], TA);
      if (i > 0)
        chk($sformatf("per_L%0d_%0d", lim, i),
            lit_s[i] - lit_s[i-1], TA + TP + 2);
    end
  endtask

  initial begin
    bit ok;
    reset   = 1'b1;
    iniciar = 1'b0;
    abortar = 1'b0;
    limite  = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
    repeat (3) @(posedge clock);
    #1;
    chk("rst_estado", db_estado, 0);
    chk("rst_end", endereco, 0);
    chk("rst_leds", leds, 0);
    chk("rst_ocup", ocupado, 0);
    chk("rst_fim", fim, 0);
    reset = 1'b0;

    play(0, 0);
    play(3, 0);
    play(15, 0);
    play(3, 1);

    // abort during second lit colour
    clr();
    limite  = 4'd3;
    iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (lit_v.size() >= 2) break;
      @(posedge clock);
    end
    #1;
    chk("ab_reach", lit_v.size(), 2);
    chk("ab_aceso", db_estado, 4'h3);
    abortar = 1'b1;
    @(posedge clock); #1 abortar = 1'b0;
    @(negedge clock);
    chk("ab_estado", db_estado, 0);
    chk("ab_leds", leds, 0);
    chk("ab_end", endereco, 0);
    chk("ab_ocup", ocupado, 0);
    repeat (5) @(negedge clock);
    chk("ab_nofim", fims, 0);
    play(3, 0);

    // reset in the middle of a blank interval
    clr();
    limite  = 4'd2;
    iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (db_estado == 4'h5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rs_reach", ok, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rs_estado", db_estado, 0);
    chk("rs_end", endereco, 0);
    chk("rs_leds", leds, 0);
    chk("rs_ocup", ocupado, 0);
    chk("rs_fim", fim, 0);
    reset   = 1'b0;
    iniciar = 1'b1;
    abortar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    abortar = 1'b0;
    chk("ia_estado", db_estado, 0);
    chk("ia_ocup", ocupado, 0);
    repeat (3) @(posedge clock);
    #1 chk("ia_stay", ocupado, 0);

    // random colours and limits
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++)
        mem[i] = 4'(1 << $urandom_range(0, 3));
      play(int'($urandom_range(0, 15)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
